// File: rtl/icache_fetcher.sv
// rtl/icache_fetcher.sv - direct-mapped icache fetch unit with sequential prefetch and dispatch queue
module icache_fetcher #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INDEX_BITS     = 8,
  parameter int QUEUE_DEPTH    = 4,
  parameter int PREFETCH_AHEAD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic [ADDR_WIDTH-1:0] query_pc_to_pdc,
  output logic [ADDR_WIDTH-1:0] query_inst_to_pdc,
  input  logic                  predicted_jump_from_pdc,
  input  logic [ADDR_WIDTH-1:0] predicted_imm_from_pdc,
  output logic                  valid_to_dsp,
  input  logic                  ready_from_dsp,
  output logic [ADDR_WIDTH-1:0] inst_to_dsp,
  output logic [ADDR_WIDTH-1:0] pc_to_dsp,
  output logic [ADDR_WIDTH-1:0] rollback_pc_to_dsp,
  output logic                  predicted_jump_to_dsp,
  output logic [ADDR_WIDTH-1:0] pc_to_mc,
  output logic                  ena_to_mc,
  output logic                  drop_flag_to_mc,
  input  logic                  ok_flag_from_mc,
  input  logic [ADDR_WIDTH-1:0] inst_from_mc,
  input  logic                  rollback_flag_from_rob,
  input  logic [ADDR_WIDTH-1:0] target_pc_from_rob,
  input  logic                  flush_icache
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(PREFETCH_AHEAD * 4);
  localparam logic [ADDR_WIDTH-1:0] WORD   = ADDR_WIDTH'(4);
  localparam logic [CNT_W-1:0]      FULL   = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pf_pc, req_pc;
  logic [ENTRIES-1:0]    line_valid;
  logic [TAG_W-1:0]      tag_mem  [ENTRIES];
  logic [ADDR_WIDTH-1:0] data_mem [ENTRIES];

  logic [ADDR_WIDTH-1:0] q_inst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_rpc  [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_jump;
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;

  logic [INDEX_BITS-1:0] pc_idx, pf_idx, req_idx;
  logic [TAG_W-1:0]      pc_tag, pf_tag, req_tag;
  logic                  hit, pf_hit, in_window;
  logic                  do_push, do_pop, push_we, fill_we;
  logic                  req_fire, pf_step;
  logic [ADDR_WIDTH-1:0] req_addr;

  assign pc_idx  = pc[INDEX_BITS+1:2];
  assign pc_tag  = pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign pf_idx  = pf_pc[INDEX_BITS+1:2];
  assign pf_tag  = pf_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign req_idx = req_pc[INDEX_BITS+1:2];
  assign req_tag = req_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  assign hit       = line_valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign pf_hit    = line_valid[pf_idx] && (tag_mem[pf_idx] == pf_tag);
  assign in_window = (pf_pc - pc) < WINDOW;

  // A full queue refuses the push even when the head pops in the same cycle.
  assign do_push = hit && (count != FULL);
  assign do_pop  = (count != '0) && ready_from_dsp;
  assign push_we = rdy && !rollback_flag_from_rob && do_push;
  assign fill_we = rdy && (state == WAIT) && ok_flag_from_mc
                   && !rollback_flag_from_rob && !flush_icache;

  assign query_pc_to_pdc       = pc;
  assign query_inst_to_pdc     = hit ? data_mem[pc_idx] : '0;
  assign valid_to_dsp          = (count != '0);
  assign inst_to_dsp           = valid_to_dsp ? q_inst[head] : '0;
  assign pc_to_dsp             = valid_to_dsp ? q_pc[head]   : '0;
  assign rollback_pc_to_dsp    = valid_to_dsp ? q_rpc[head]  : '0;
  assign predicted_jump_to_dsp = valid_to_dsp && q_jump[head];

  always_comb begin
    state_next = state;
    req_fire   = 1'b0;
    req_addr   = pc;
    pf_step    = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          req_fire   = 1'b1;
          state_next = WAIT;
        end else if (in_window && pf_hit) begin
          pf_step = 1'b1;
        end else if (in_window) begin
          req_fire   = 1'b1;
          req_addr   = pf_pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ok_flag_from_mc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cache and queue payload arrays carry no reset; valid bits and count guard them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= inst_from_mc;
    end
    if (push_we) begin
      q_inst[tail] <= data_mem[pc_idx];
      q_pc[tail]   <= pc;
      q_rpc[tail]  <= pc + WORD;
      q_jump[tail] <= predicted_jump_from_pdc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pc              <= '0;
      pf_pc           <= '0;
      req_pc          <= '0;
      line_valid      <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      pc_to_mc        <= '0;
      ena_to_mc       <= 1'b0;
      drop_flag_to_mc <= 1'b0;
    end else if (rdy) begin
      ena_to_mc       <= 1'b0;
      drop_flag_to_mc <= 1'b0;
      if (rollback_flag_from_rob) begin
        state           <= IDLE;
        pc              <= target_pc_from_rob;
        pf_pc           <= target_pc_from_rob;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        drop_flag_to_mc <= (state == WAIT);
      end else begin
        state <= state_next;
        if (req_fire) begin
          ena_to_mc <= 1'b1;
          pc_to_mc  <= req_addr;
          req_pc    <= req_addr;
        end
        if (pf_step) pf_pc <= pf_pc + WORD;
        if (fill_we) pf_pc <= req_pc + WORD;
        if (do_push) begin
          tail <= tail + 1'b1;
          pc   <= pc + (predicted_jump_from_pdc ? predicted_imm_from_pdc : WORD);
        end
        if (do_pop) head <= head + 1'b1;
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
      if (fill_we) line_valid[req_idx] <= 1'b1;
      if (flush_icache) line_valid <= '0;
    end
  end

endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
- Parametrised next-generation instruction fetch unit.
- Holds a direct-mapped icache of 2^INDEX_BITS words, prefetches sequentially up to PREFETCH_AHEAD words ahead of the fetch PC, and consults the predictor on every hit.
- Delivers instructions through a QUEUE_DEPTH-entry valid/ready queue to the dispatcher, replacing the single-register, full-signal interface.
- Sits between memctrl, predictor, dispatcher and ROB.

Parameters:
ADDR_WIDTH, 32, PC and instruction width.
INDEX_BITS, 8, icache index bits: entries = 2^INDEX_BITS, index = pc[INDEX_BITS+1:2], tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
QUEUE_DEPTH, 4, output queue entries; power of two, at least 2.
PREFETCH_AHEAD, 4, maximum words the prefetch pointer may lead pc.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low freezes all state
query_pc_to_pdc  out  ADDR_WIDTH  current pc
query_inst_to_pdc  out  ADDR_WIDTH  cached word at pc, 0 on miss
predicted_jump_from_pdc  in  1  predicted taken
predicted_imm_from_pdc  in  ADDR_WIDTH  predicted offset
valid_to_dsp  out  1  queue head valid
ready_from_dsp  in  1  dispatcher accepts head
inst_to_dsp  out  ADDR_WIDTH  head instruction
pc_to_dsp  out  ADDR_WIDTH  head pc
rollback_pc_to_dsp  out  ADDR_WIDTH  head pc+4
predicted_jump_to_dsp  out  1  head prediction
pc_to_mc  out  ADDR_WIDTH  request address
ena_to_mc  out  1  one-cycle request pulse
drop_flag_to_mc  out  1  one-cycle abort of outstanding request
ok_flag_from_mc  in  1  request complete
inst_from_mc  in  ADDR_WIDTH  returned word
rollback_flag_from_rob  in  1  mispredict flush
target_pc_from_rob  in  ADDR_WIDTH  redirect pc
flush_icache  in  1  invalidate all icache lines (fence.i)

Behaviour:
- Reset (rst=0, async): all valid bits 0; pc=0; pf_pc=0; req_pc=0; state IDLE; queue empty. Outputs: valid_to_dsp=0, all data outputs 0, ena/drop=0. Tag/data arrays are not reset.
- rdy=0: no state changes, no pops; outputs hold.
- Priority per cycle: reset > rdy > rollback > normal.
- Hit: valid[idx(pc)] && tag==tag(pc). Combinational.
- Push: if hit and count<QUEUE_DEPTH, write {inst, pc, pc+4, predicted_jump} and set pc <= pc + (jump ? imm : 4). Full blocks push even if a pop occurs the same cycle.
- Latency: hit at cycle N gives valid_to_dsp=1 at N+1 when the queue was empty.
- Pop: valid_to_dsp && ready_from_dsp. Head outputs are driven from registered storage. Pointers wrap modulo QUEUE_DEPTH; count tracks push/pop, including simultaneous push+pop.
- Memctrl FSM states: IDLE, WAIT.
- IDLE, in decreasing precedence:
  - !hit: pc_to_mc=pc, req_pc=pc, ena_to_mc=1, go to WAIT.
  - d=(pf_pc-pc) mod 2^ADDR_WIDTH < PREFETCH_AHEAD*4 and pf_pc cached: pf_pc += 4, no request.
  - d in window and pf_pc uncached: request pf_pc, go to WAIT.
  - Otherwise remain IDLE with no request.
- WAIT: ena_to_mc=0. On ok_flag_from_mc: write valid/tag/data at req_pc, pf_pc <= req_pc+4, go to IDLE. One request is outstanding at most.
- Rollback: queue emptied (valid_to_dsp=0 next cycle); pc=pf_pc=target; state IDLE; ena=0. If state was WAIT, drop_flag_to_mc=1 for exactly one cycle. An ok_flag in the same cycle is discarded with no cache write. Cache contents are kept.
- flush_icache: all valid bits cleared next cycle. An ok_flag in the same cycle is not written; a later fill for an outstanding request is written. Queue is unaffected.
- Both rollback and flush_icache asserted: both take effect.
- All pc arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Cold start, memctrl 3-cycle latency, words at 0x0,0x4,0x8 -> ena pulses at pc 0x0 then prefetch 0x4, 0x8, 0xC. valid_to_dsp rises one cycle after each fill. pc_to_dsp sequence 0x0,0x4,0x8; rollback_pc_to_dsp 0x4,0x8,0xC.
- Hold ready_from_dsp=0 with QUEUE_DEPTH=4 -> exactly 4 entries queued, pc stalls at 0x10. Raise ready -> one pop per cycle in order; push resumes after the first pop.
- Prefetch limit: pc stalls with pf_pc=pc+16, PREFETCH_AHEAD=4 -> no further ena_to_mc.
- Predictor taken with imm=0x20 at pc 0x8 -> next pushed pc 0x28, predicted_jump_to_dsp=1, rollback_pc_to_dsp=0xC. Miss at 0x28 issues request 0x28.
- Rollback to 0x100 while in WAIT, plus ok_flag in the same cycle -> drop_flag_to_mc one cycle, no cache write, queue empty, next request 0x100.
- flush_icache after filling 0x0..0xC, then rollback to 0x0 -> miss, ena_to_mc with pc_to_mc=0x0. Assert rst low mid-WAIT -> all outputs 0 immediately, without waiting for clk.
